// File: rtl/row_scan_decoder.sv
// Row scan decoder: manual one-hot decode of a line index, or an automatic
// scan that drives each select line in turn for `dwell` cycles, separated by
// `gap` all-zero cycles, and pulses `done` once the last line is released.
//
// Ports:
//   clk     - single clock, rising edge
//   reset   - synchronous, active-high
//   enable  - manual-mode output enable
//   select  - manual-mode line index
//   mode    - 0 = manual decode, 1 = auto-scan (sampled in IDLE only)
//   start   - scan request (sampled in IDLE with mode=1)
//   abort   - terminates a scan in progress
//   out     - registered one-hot (or all-zero) select lines
//   row     - index of the current or last driven scan row
//   busy    - high while a scan is in progress (DRIVE or GAP)
//   done    - one-cycle pulse on scan completion
module row_scan_decoder #(
   parameter int unsigned width = 8,
   parameter int unsigned dwell = 4,
   parameter int unsigned gap   = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic [$clog2(width)-1:0]   select,
   input  logic                       mode,
   input  logic                       start,
   input  logic                       abort,
   output logic [width-1:0]           out,
   output logic [$clog2(width)-1:0]   row,
   output logic                       busy,
   output logic                       done
);

   localparam int unsigned RW  = $clog2(width);
   localparam int unsigned DCW = (dwell > 1) ? $clog2(dwell) : 1;
   localparam int unsigned GCW = (gap > 1) ? $clog2(gap) : 1;

   localparam logic [RW-1:0]  ROW_LAST   = RW'(width - 1);
   localparam logic [DCW-1:0] DWELL_LAST = DCW'(dwell - 1);
   localparam logic [GCW-1:0] GAP_LAST   = GCW'((gap > 0) ? gap - 1 : 0);
   localparam bit             HAS_GAP    = (gap != 0);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [width-1:0] out_d;
   logic [RW-1:0]    row_d;
   logic             busy_d;
   logic             done_d;
   logic [DCW-1:0]   dcnt_q, dcnt_d;
   logic [GCW-1:0]   gcnt_q, gcnt_d;
   logic [RW-1:0]    row_nxt;

   assign row_nxt = row_q_plus_one(row);

   function automatic logic [RW-1:0] row_q_plus_one(input logic [RW-1:0] r);
      return r + RW'(1);
   endfunction

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         out     <= '0;
         row     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         dcnt_q  <= '0;
         gcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         out     <= out_d;
         row     <= row_d;
         busy    <= busy_d;
         done    <= done_d;
         dcnt_q  <= dcnt_d;
         gcnt_q  <= gcnt_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      out_d   = out;
      row_d   = row;
      busy_d  = busy;
      done_d  = 1'b0;
      dcnt_d  = dcnt_q;
      gcnt_d  = gcnt_q;

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (mode) begin
               out_d = '0;
               // start wins over a simultaneous abort: abort is meaningless here
               if (start) begin
                  state_d = DRIVE;
                  row_d   = '0;
                  out_d   = width'(1);
                  busy_d  = 1'b1;
                  dcnt_d  = '0;
               end
            end else begin
               // Out-of-range indices (non power-of-two widths) decode to zero
               out_d = (enable && (32'(select) < width)) ? (width'(1) << select) : '0;
            end
         end

         DRIVE: begin
            if (abort) begin
               state_d = IDLE;
               out_d   = '0;
               busy_d  = 1'b0;
            end else if (dcnt_q == DWELL_LAST) begin
               if (row == ROW_LAST) begin
                  state_d = IDLE;
                  out_d   = '0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else if (HAS_GAP) begin
                  state_d = GAP;
                  out_d   = '0;
                  gcnt_d  = '0;
               end else begin
                  row_d  = row_nxt;
                  out_d  = width'(1) << row_nxt;
                  dcnt_d = '0;
               end
            end else begin
               dcnt_d = dcnt_q + DCW'(1);
            end
         end

         GAP: begin
            if (abort) begin
               state_d = IDLE;
               out_d   = '0;
               busy_d  = 1'b0;
            end else if (gcnt_q == GAP_LAST) begin
               state_d = DRIVE;
               row_d   = row_nxt;
               out_d   = width'(1) << row_nxt;
               dcnt_d  = '0;
            end else begin
               gcnt_d = gcnt_q + GCW'(1);
            end
         end

         default: begin
            state_d = IDLE;
            out_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_row_scan_decoder.sv
// Directed bench for row_scan_decoder: manual decode, full scans (gap=1 and
// gap=0 builds), abort corner cases and mid-scan reset.
module tb_row_scan_decoder;

   logic       clk = 1'b0;
   logic       reset, enable, mode, start, abort;
   logic [2:0] select;
   logic [7:0] out, g0_out;
   logic [2:0] row, g0_row;
   logic       busy, done, g0_busy, g0_done;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   row_scan_decoder #(.width(8), .dwell(4), .gap(1)) dut (
      .clk(clk), .reset(reset), .enable(enable), .select(select), .mode(mode),
      .start(start), .abort(abort), .out(out), .row(row), .busy(busy), .done(done)
   );

   row_scan_decoder #(.width(8), .dwell(4), .gap(0)) dut_g0 (
      .clk(clk), .reset(reset), .enable(enable), .select(select), .mode(mode),
      .start(start), .abort(abort), .out(g0_out), .row(g0_row), .busy(g0_busy),
      .done(g0_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Full gap=1 scan; with disturb, start/mode/enable/select wiggle while busy
   task automatic run_scan(input bit disturb);
      logic [7:0] e_out;
      mode  = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c <= 40; c++) begin
         e_out = (c < 39 && (c % 5) < 4) ? (8'd1 << (c / 5)) : 8'd0;
         chk($sformatf("scan_out[%0d]", c), 32'(out), 32'(e_out));
         chk($sformatf("scan_row[%0d]", c), 32'(row), (c < 39) ? 32'(c / 5) : 32'd7);
         chk($sformatf("scan_busy[%0d]", c), 32'(busy), (c < 39) ? 32'd1 : 32'd0);
         chk($sformatf("scan_done[%0d]", c), 32'(done), (c == 39) ? 32'd1 : 32'd0);
         if (disturb && c < 38) begin
            start  = c[0];
            mode   = ~mode;
            enable = 1'b1;
            select = 3'(c);
         end else begin
            start  = 1'b0;
            mode   = 1'b1;
            enable = 1'b0;
         end
         tick();
      end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; mode = 1'b0; start = 1'b0; abort = 1'b0; select = '0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_out", 32'(out), 32'd0);
      chk("rst_row", 32'(row), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);

      // Manual decode
      enable = 1'b1; select = 3'd3; tick();
      chk("man_sel3", 32'(out), 32'h08);
      enable = 1'b0; tick();
      chk("man_dis", 32'(out), 32'h00);
      enable = 1'b1; select = 3'd5; tick();
      chk("man_sel5", 32'(out), 32'h20);
      select = 3'd0; tick();
      chk("man_sel0", 32'(out), 32'h01);
      chk("man_busy", 32'(busy), 32'd0);
      enable = 1'b0;

      // Scan mode idle without start
      mode = 1'b1; enable = 1'b1; tick();
      chk("scan_idle_out", 32'(out), 32'd0);
      enable = 1'b0;

      run_scan(1'b0);
      run_scan(1'b1);

      // Abort during row 2, then start+abort together restarts at row 0
      mode = 1'b1; start = 1'b1; tick(); start = 1'b0;
      repeat (10) tick();
      chk("ab_pre_out", 32'(out), 32'h04);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("ab_out", 32'(out), 32'd0);
      chk("ab_busy", 32'(busy), 32'd0);
      chk("ab_row", 32'(row), 32'd2);
      chk("ab_done", 32'(done), 32'd0);
      tick();
      chk("ab_done2", 32'(done), 32'd0);
      chk("ab_out2", 32'(out), 32'd0);
      start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
      chk("restart_out", 32'(out), 32'h01);
      chk("restart_row", 32'(row), 32'd0);
      chk("restart_busy", 32'(busy), 32'd1);

      // Abort coinciding with dwell expiry of row 0 (would otherwise enter GAP)
      repeat (3) tick();
      abort = 1'b1; tick(); abort = 1'b0;
      chk("ab_exp_busy", 32'(busy), 32'd0);
      chk("ab_exp_out", 32'(out), 32'd0);
      chk("ab_exp_row", 32'(row), 32'd0);

      // Abort coinciding with expiry of the last row: no done
      start = 1'b1; tick(); start = 1'b0;
      repeat (38) tick();
      chk("ab_last_pre", 32'(out), 32'h80);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("ab_last_done", 32'(done), 32'd0);
      chk("ab_last_busy", 32'(busy), 32'd0);
      chk("ab_last_row", 32'(row), 32'd7);

      // Abort in IDLE has no effect on manual decode
      mode = 1'b0; enable = 1'b1; select = 3'd2; abort = 1'b1; tick(); abort = 1'b0;
      chk("ab_idle_out", 32'(out), 32'h04);
      chk("ab_idle_busy", 32'(busy), 32'd0);
      enable = 1'b0;

      // Reset during row 4
      mode = 1'b1; start = 1'b1; tick(); start = 1'b0;
      repeat (20) tick();
      chk("rs_pre_out", 32'(out), 32'h10);
      chk("rs_pre_row", 32'(row), 32'd4);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("rs_out", 32'(out), 32'd0);
      chk("rs_row", 32'(row), 32'd0);
      chk("rs_busy", 32'(busy), 32'd0);
      chk("rs_done", 32'(done), 32'd0);
      tick();
      chk("rs_done2", 32'(done), 32'd0);
      chk("rs_out2", 32'(out), 32'd0);

      // gap=0 build: back-to-back rows, 32-cycle scan
      start = 1'b1; tick(); start = 1'b0;
      for (int c = 0; c <= 33; c++) begin
         chk($sformatf("g0_out[%0d]", c), 32'(g0_out),
             (c < 32) ? (32'd1 << (c / 4)) : 32'd0);
         chk($sformatf("g0_busy[%0d]", c), 32'(g0_busy), (c < 32) ? 32'd1 : 32'd0);
         chk($sformatf("g0_done[%0d]", c), 32'(g0_done), (c == 32) ? 32'd1 : 32'd0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/row_scan_decoder.md
ROW_SCAN_DECODER -- requirements
Module: row_scan_decoder

Interface
REQ-001 The block SHALL have parameter width, default 8, number of select lines (>=2).
REQ-002 The block SHALL have parameter dwell, default 4, cycles each row is held active in scan mode (>=1).
REQ-003 The block SHALL have parameter gap, default 1, all-zero non-overlap cycles between rows in scan mode (>=0).
REQ-004 The block SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port enable  input  1  manual-mode output enable.
REQ-007 The block SHALL have port select  input  $clog2(width)  manual-mode line index.
REQ-008 The block SHALL have port mode  input  1  0 = manual decode, 1 = auto-scan; sampled only in IDLE.
REQ-009 The block SHALL have port start  input  1  scan request, sampled only in IDLE with mode=1.
REQ-010 The block SHALL have port abort  input  1  terminates a scan in progress.
REQ-011 The block SHALL have port out  output  width  registered one-hot (or all-zero) select lines.
REQ-012 The block SHALL have port row  output  $clog2(width)  index of the current or last driven scan row.
REQ-013 The block SHALL have port busy  output  1  high in DRIVE and GAP states.
REQ-014 The block SHALL have port done  output  1  one-cycle pulse on scan completion.

Function
REQ-015 The FSM SHALL have states IDLE, DRIVE, GAP; all outputs registered.
REQ-016 In IDLE with mode=0, out SHALL equal enable ? (1 << select) : 0, one cycle after sampling.
REQ-017 In manual mode, select >= width SHALL give out = 0.
REQ-018 In IDLE with mode=1 and start=0, out SHALL be 0.
REQ-019 IDLE with mode=1 and start=1 SHALL go to DRIVE with row=0; out=1 from the next cycle.
REQ-020 DRIVE SHALL hold out = 1 << row for exactly dwell cycles, timed by a dwell counter.
REQ-021 At dwell expiry with row < width-1, the FSM SHALL enter GAP (out=0) for gap cycles, then DRIVE row+1.
REQ-022 With gap=0, the FSM SHALL go DRIVE row to DRIVE row+1 directly, with no zero cycle.
REQ-023 At dwell expiry with row = width-1, the FSM SHALL return to IDLE, set out=0 and pulse done for exactly one cycle.
REQ-024 done SHALL go high in the first cycle out is 0 after the last row.
REQ-025 Total scan length, from the first active out cycle to the cycle before done, SHALL be width*dwell + (width-1)*gap cycles.
REQ-026 Neither two out bits nor out and done SHALL be high in the same cycle.
REQ-027 start, mode, enable and select SHALL be ignored while busy.
REQ-028 abort while busy SHALL force IDLE and out=0 on the next cycle, with no done pulse and row holding its last value.
REQ-029 abort in IDLE SHALL have no effect.
REQ-030 When abort and dwell expiry occur in the same cycle, abort SHALL win.
REQ-031 start and abort high together in IDLE SHALL start a scan.
REQ-032 row SHALL not wrap past width-1.
REQ-033 A new scan SHALL always restart at row 0.

Reset
REQ-034 reset SHALL force, at the next clk edge, state=IDLE, out=0, row=0, busy=0, done=0 and the dwell and gap counters to 0.
REQ-035 reset SHALL take priority over all inputs, including mid-scan, and SHALL NOT generate a done pulse.

Verification (width=8, dwell=4, gap=1)
REQ-036 The bench SHALL check: manual mode, enable=1, select=3 -> out=00001000 next cycle; then enable=0 -> out=00000000.
REQ-037 The bench SHALL check: manual mode, select=5 then select=0, enable=1 -> out=00100000, then out=00000001, each one cycle after the change.
REQ-038 The bench SHALL check: mode=1, start pulse -> out=00000001 for 4 cycles, 00000000 for 1 cycle, then 00000010, and so on through 10000000; done pulses once, 39 cycles after the first active cycle; busy=1 for 39 cycles.
REQ-039 The bench SHALL check: abort during row 2 -> out=0 next cycle, busy=0, row=2, no done; a following start begins again at row 0.
REQ-040 The bench SHALL check: start re-pulsed and mode toggled mid-scan -> timing is unchanged from REQ-038.
REQ-041 The bench SHALL check: reset asserted during row 4 -> next cycle all outputs are 0 and no done occurs; a gap=0 build shows no zero cycles between rows and a 32-cycle scan.
